// File: rtl/fft_level_sequencer_if.sv
// Handshake bundle between the FFT level sequencer and the address generator / frame controller.
// The sequencer side uses the master modport; the environment side uses slave.
interface fft_level_sequencer_if #(
    parameter int FFT_SIZE = 4096
);
    localparam int LEVELS  = $clog2(FFT_SIZE);
    localparam int LEVEL_W = (LEVELS > 1) ? $clog2(LEVELS) : 1;

    logic               fft_start;
    logic               fft_busy;
    logic               fft_done;
    logic               fft_error;
    logic               addr_gen_go;
    logic               addr_gen_busy;
    logic               fft_data_valid;
    logic [LEVEL_W-1:0] fft_level;
    logic               bank_sel;
    logic               level_done;

    modport master (
        input  fft_start, addr_gen_busy, fft_data_valid,
        output fft_busy, fft_done, fft_error, addr_gen_go, fft_level, bank_sel, level_done
    );

    modport slave (
        output fft_start, addr_gen_busy, fft_data_valid,
        input  fft_busy, fft_done, fft_error, addr_gen_go, fft_level, bank_sel, level_done
    );
endinterface

// File: rtl/fft_level_sequencer.sv
// Launches the FFT address generator once per radix-2 level, waits for the butterfly
// pipeline to drain between levels, and reports frame done / generator-unresponsive error.
module fft_level_sequencer #(
    parameter int FFT_SIZE     = 4096,
    parameter int LEVELS       = $clog2(FFT_SIZE),
    parameter int BFLY_LATENCY = 7
) (
    input  logic                         clk,
    input  logic                         reset,
    fft_level_sequencer_if.master        bus
);
    localparam int LEVEL_W = (LEVELS > 1) ? $clog2(LEVELS) : 1;
    localparam int CNT_W   = $clog2(BFLY_LATENCY + 1);
    localparam logic [LEVEL_W-1:0] LAST_LEVEL = LEVEL_W'(LEVELS - 1);
    localparam logic [CNT_W-1:0]   CNT_MAX    = CNT_W'(BFLY_LATENCY);
    localparam logic [CNT_W-1:0]   CNT_EXIT   = CNT_W'(BFLY_LATENCY - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LAUNCH = 3'd1,
        S_ARM    = 3'd2,
        S_RUN    = 3'd3,
        S_DRAIN  = 3'd4,
        S_NEXT   = 3'd5,
        S_DONE   = 3'd6,
        S_ERROR  = 3'd7
    } state_t;

    state_t             state_r;
    state_t             state_s;
    logic [LEVEL_W-1:0] level_r;
    logic               bank_r;
    logic [CNT_W-1:0]   drain_cnt_r;
    logic               busy_r;
    logic               done_r;
    logic               error_r;
    logic               go_r;
    logic               level_done_r;

    // Next-state decode.
    always_comb begin
        state_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (bus.fft_start) state_s = S_LAUNCH;
                else               state_s = S_IDLE;
            end
            S_LAUNCH: state_s = S_ARM;
            S_ARM: begin
                if (bus.addr_gen_busy) state_s = S_RUN;
                else                   state_s = S_ERROR;
            end
            S_RUN: begin
                if (bus.addr_gen_busy) state_s = S_RUN;
                else                   state_s = S_DRAIN;
            end
            S_DRAIN: begin
                // Wait for both the latency floor and the last write-back beat.
                if (!bus.fft_data_valid && (drain_cnt_r >= CNT_EXIT)) state_s = S_NEXT;
                else                                                  state_s = S_DRAIN;
            end
            S_NEXT: begin
                if (level_r == LAST_LEVEL) state_s = S_DONE;
                else                       state_s = S_LAUNCH;
            end
            S_DONE: state_s = S_IDLE;
            S_ERROR: begin
                if (bus.fft_start) state_s = S_LAUNCH;
                else               state_s = S_ERROR;
            end
            default: state_s = S_IDLE;
        endcase
    end

    // State register plus outputs registered from the next-state decode.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= S_IDLE;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            error_r      <= 1'b0;
            go_r         <= 1'b0;
            level_done_r <= 1'b0;
        end else begin
            state_r      <= state_s;
            busy_r       <= (state_s inside {S_LAUNCH, S_ARM, S_RUN, S_DRAIN, S_NEXT, S_DONE});
            done_r       <= (state_s == S_DONE);
            error_r      <= (state_s == S_ERROR);
            go_r         <= (state_s == S_LAUNCH);
            level_done_r <= (state_s == S_NEXT);
        end
    end

    // Level index, ping-pong bank and drain counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            level_r     <= {LEVEL_W{1'b0}};
            bank_r      <= 1'b0;
            drain_cnt_r <= {CNT_W{1'b0}};
        end else begin
            if (((state_r == S_IDLE) || (state_r == S_ERROR)) && bus.fft_start) begin
                level_r <= {LEVEL_W{1'b0}};
                bank_r  <= 1'b0;
            end else if ((state_r == S_NEXT) && (level_r != LAST_LEVEL)) begin
                level_r <= level_r + LEVEL_W'(1);
                bank_r  <= ~bank_r;
            end
            if (state_r == S_RUN) begin
                drain_cnt_r <= {CNT_W{1'b0}};
            end else if ((state_r == S_DRAIN) && (drain_cnt_r < CNT_MAX)) begin
                drain_cnt_r <= drain_cnt_r + CNT_W'(1);
            end
        end
    end

    assign bus.fft_busy    = busy_r;
    assign bus.fft_done    = done_r;
    assign bus.fft_error   = error_r;
    assign bus.addr_gen_go = go_r;
    assign bus.fft_level   = level_r;
    assign bus.bank_sel    = bank_r;
    assign bus.level_done  = level_done_r;
endmodule

// File: tb/tb_fft_level_sequencer.sv
// Self-checking bench for fft_level_sequencer: behavioural address generators, an event
// scoreboard per instance, a frame table and hand sequences for error/reset corners.
module tb_fft_level_sequencer;
    localparam int BIG_N    = 4096;
    localparam int BIG_LV   = 12;
    localparam int SMALL_N  = 16;
    localparam int SMALL_LV = 4;
    localparam int BL       = 7;
    localparam int EXT      = 20;
    localparam int PERIOD   = BIG_N / 2 + 10;
    localparam int EV_GO    = 0;
    localparam int EV_LD    = 1;
    localparam int EV_DONE  = 2;

    typedef struct {
        int kind;
        int cyc;
        int level;
        bit bank;
    } ev_t;

    typedef struct {
        int ext_level;
        bit glitch;
        int exp_done;
        bit exp_bank;
    } frame_vec_t;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    ev_t  big_q[$];
    ev_t  small_q[$];
    bit   gen_dead;
    int   ext_level;

    int             gen_cnt_b, ext_cnt_b, gen_cnt_s;
    logic [BL-1:0]  hist_b, hist_s;

    always #5 clk = ~clk;

    // free-running cycle index, read on the falling edge
    always @(posedge clk) cyc <= cyc + 1;

    fft_level_sequencer_if #(.FFT_SIZE(BIG_N))   bif ();
    fft_level_sequencer_if #(.FFT_SIZE(SMALL_N)) sif ();

    fft_level_sequencer #(.FFT_SIZE(BIG_N), .BFLY_LATENCY(BL)) dut_big (
        .clk(clk), .reset(reset), .bus(bif.master));
    fft_level_sequencer #(.FFT_SIZE(SMALL_N), .BFLY_LATENCY(BL)) dut_small (
        .clk(clk), .reset(reset), .bus(sif.master));

    // generator model: busy N/2 cycles after go, valid = busy delayed BL, optional valid stretch
    always @(posedge clk) begin
        if (reset) begin
            gen_cnt_b <= 0; ext_cnt_b <= 0; hist_b <= '0;
            gen_cnt_s <= 0; hist_s <= '0;
        end else begin
            if (bif.addr_gen_go && !gen_dead) gen_cnt_b <= BIG_N / 2;
            else if (gen_cnt_b > 0)           gen_cnt_b <= gen_cnt_b - 1;
            hist_b <= {hist_b[BL-2:0], bif.addr_gen_busy};
            if (hist_b[BL-1] && !hist_b[BL-2] && (ext_level == int'(bif.fft_level))) ext_cnt_b <= EXT;
            else if (ext_cnt_b > 0) ext_cnt_b <= ext_cnt_b - 1;
            if (sif.addr_gen_go)    gen_cnt_s <= SMALL_N / 2;
            else if (gen_cnt_s > 0) gen_cnt_s <= gen_cnt_s - 1;
            hist_s <= {hist_s[BL-2:0], sif.addr_gen_busy};
        end
    end

    assign bif.addr_gen_busy  = (gen_cnt_b != 0);
    assign bif.fft_data_valid = hist_b[BL-1] || (ext_cnt_b != 0);
    assign sif.addr_gen_busy  = (gen_cnt_s != 0);
    assign sif.fft_data_valid = hist_s[BL-1];

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_ev(input int id, input ev_t e);
        if (id == 0) big_q.push_back(e);
        else         small_q.push_back(e);
    endtask

    // Expected go / level_done / done events for one frame; stop_lvl truncates after that go.
    task automatic push_frame(input int id, input int t0, input int n, input int lv,
                              input int ext_lvl, input int stop_lvl);
        int  t;
        ev_t e;
        t = t0 + 1;
        for (int l = 0; l < lv; l++) begin
            e = '{EV_GO, t, l, 1'(l & 1)};
            push_ev(id, e);
            if (l == stop_lvl) return;
            t = t + n / 2 + 9 + ((l == ext_lvl) ? EXT : 0);
            e = '{EV_LD, t, l, 1'(l & 1)};
            push_ev(id, e);
            t = t + 1;
        end
        e = '{EV_DONE, t, lv - 1, 1'((lv - 1) & 1)};
        push_ev(id, e);
    endtask

    task automatic observe(input int id, input int kind, input int lvl, input bit bank);
        ev_t e;
        int  sz;
        string tag;
        sz  = (id == 0) ? big_q.size() : small_q.size();
        tag = $sformatf("dut%0d_ev%0d", id, kind);
        check({tag, "_expected"}, longint'(sz != 0), 1);
        if (sz != 0) begin
            if (id == 0) e = big_q.pop_front();
            else         e = small_q.pop_front();
            check({tag, "_kind"},  kind, e.kind);
            check({tag, "_cycle"}, cyc,  e.cyc);
            check({tag, "_level"}, lvl,  e.level);
            check({tag, "_bank"},  bank, e.bank);
        end
    endtask

    // scoreboard monitor: every pulse must match the next queued event of that instance
    always @(negedge clk) begin
        if (bif.addr_gen_go) observe(0, EV_GO,   int'(bif.fft_level), bif.bank_sel);
        if (bif.level_done)  observe(0, EV_LD,   int'(bif.fft_level), bif.bank_sel);
        if (bif.fft_done)    observe(0, EV_DONE, int'(bif.fft_level), bif.bank_sel);
        if (sif.addr_gen_go) observe(1, EV_GO,   int'(sif.fft_level), sif.bank_sel);
        if (sif.level_done)  observe(1, EV_LD,   int'(sif.fft_level), sif.bank_sel);
        if (sif.fft_done)    observe(1, EV_DONE, int'(sif.fft_level), sif.bank_sel);
    end

    task automatic check_idle_outputs(input string tag);
        check({tag, "_busy"},       bif.fft_busy,    0);
        check({tag, "_done"},       bif.fft_done,    0);
        check({tag, "_error"},      bif.fft_error,   0);
        check({tag, "_go"},         bif.addr_gen_go, 0);
        check({tag, "_level_done"}, bif.level_done,  0);
        check({tag, "_bank"},       bif.bank_sel,    0);
        check({tag, "_level"},      bif.fft_level,   0);
    endtask

    initial begin
        frame_vec_t vecs[2];
        int  t0, done_at;
        bit  done_seen;
        vecs[0] = '{-1, 1'b1, 24697, 1'b1};
        vecs[1] = '{ 3, 1'b0, 24717, 1'b1};

        reset = 1'b1; bif.fft_start = 1'b0; sif.fft_start = 1'b0;
        gen_dead = 1'b0; ext_level = -1;
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        check("reset_small_busy", sif.fft_busy, 0);
        reset = 1'b0;
        @(negedge clk);

        // unresponsive generator: ERROR in cycle 3, sticky, then restart clears it
        gen_dead = 1'b1;
        t0 = cyc; push_frame(0, t0, BIG_N, BIG_LV, -1, 0);
        bif.fft_start = 1'b1;
        @(negedge clk); bif.fft_start = 1'b0;
        @(negedge clk);
        check("err_not_yet", bif.fft_error, 0);
        @(negedge clk);
        check("err_cycle3", bif.fft_error, 1);
        check("err_busy_low", bif.fft_busy, 0);
        repeat (10) @(negedge clk);
        check("err_sticky", bif.fft_error, 1);
        check("err_no_more_go", big_q.size(), 0);
        t0 = cyc; push_frame(0, t0, BIG_N, BIG_LV, -1, 0);
        bif.fft_start = 1'b1;
        @(negedge clk); bif.fft_start = 1'b0;
        check("err_cleared", bif.fft_error, 0);
        check("err_relaunch_busy", bif.fft_busy, 1);
        check("err_relaunch_level", bif.fft_level, 0);
        repeat (2) @(negedge clk);
        check("err_again", bif.fft_error, 1);
        reset = 1'b1; @(negedge clk); reset = 1'b0;
        check("err_reset_clears", bif.fft_error, 0);
        gen_dead = 1'b0;
        @(negedge clk);

        // reset in RUN of level 7
        t0 = cyc; push_frame(0, t0, BIG_N, BIG_LV, -1, 7);
        bif.fft_start = 1'b1;
        @(negedge clk); bif.fft_start = 1'b0;
        repeat (1 + PERIOD * 7 + 100 - 1) @(negedge clk);
        check("mid_level7", bif.fft_level, 7);
        check("mid_busy", bif.fft_busy, 1);
        reset = 1'b1;
        @(negedge clk);
        check_idle_outputs("midreset");
        reset = 1'b0;
        check("midreset_queue", big_q.size(), 0);
        repeat (40) @(negedge clk);
        check("midreset_quiet_go", bif.addr_gen_go, 0);

        // frame table: nominal frame with ignored start pulses, then stretched drain in level 3
        for (int i = 0; i < 2; i++) begin
            ext_level = vecs[i].ext_level;
            t0 = cyc; push_frame(0, t0, BIG_N, BIG_LV, vecs[i].ext_level, -1);
            bif.fft_start = 1'b1;
            done_seen = 1'b0; done_at = -1;
            for (int c = 1; c < 26000 && !done_seen; c++) begin
                @(negedge clk);
                bif.fft_start = vecs[i].glitch && ((c == 1 + PERIOD * 5 + 300) || bif.fft_done);
                if (bif.fft_done) begin
                    done_seen = 1'b1;
                    done_at = c;
                end
            end
            check($sformatf("row%0d_done_seen", i), done_seen, 1);
            check($sformatf("row%0d_done_cycle", i), done_at, vecs[i].exp_done);
            @(negedge clk);
            bif.fft_start = 1'b0;
            check($sformatf("row%0d_busy_after", i), bif.fft_busy, 0);
            check($sformatf("row%0d_done_once", i), bif.fft_done, 0);
            check($sformatf("row%0d_final_bank", i), bif.bank_sel, vecs[i].exp_bank);
            repeat (5) @(negedge clk);
            check($sformatf("row%0d_bank_hold", i), bif.bank_sel, vecs[i].exp_bank);
            check($sformatf("row%0d_queue_empty", i), big_q.size(), 0);
        end

        // 16-point instance: four levels, period 18
        t0 = cyc; push_frame(1, t0, SMALL_N, SMALL_LV, -1, -1);
        sif.fft_start = 1'b1;
        done_seen = 1'b0; done_at = -1;
        for (int c = 1; c < 200 && !done_seen; c++) begin
            @(negedge clk);
            sif.fft_start = 1'b0;
            if (sif.fft_done) begin
                done_seen = 1'b1;
                done_at = c;
            end
        end
        check("small_done_seen", done_seen, 1);
        check("small_done_cycle", done_at, 73);
        check("small_final_level", sif.fft_level, 3);
        repeat (3) @(negedge clk);
        check("small_queue_empty", small_q.size(), 0);
        check("small_busy_after", sif.fft_busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/fft_level_sequencer.md
# fft_level_sequencer

Control stage directly upstream of the FFT address generator. On a frame start it launches the generator once per FFT level (`LEVELS` = log2(`FFT_SIZE`) levels), presents the current level index and ping-pong bank select, and waits for each level's butterfly pipeline to drain before launching the next. It reports frame completion with a one-cycle done pulse and flags a generator that fails to respond.

## Interface
- `FFT_SIZE`, 4096, transform points; power of two, ≥ 4
- `LEVELS`, log2(`FFT_SIZE`) (12), number of radix-2 levels
- `BFLY_LATENCY`, 7, cycles from read address to write-back valid in the butterfly path
- `clk` in 1: single clock; all logic on rising edge
- `reset` in 1: synchronous, active-high
- `fft_start` in 1: frame start request; sampled only in IDLE or ERROR
- `fft_busy` out 1: high from LAUNCH of level 0 through DONE inclusive
- `fft_done` out 1: one-cycle pulse, frame complete
- `fft_error` out 1: sticky; generator did not go busy after launch
- `addr_gen_go` out 1: one-cycle launch pulse to the address generator
- `addr_gen_busy` in 1: generator counting butterflies
- `fft_data_valid` in 1: delayed write-back valid from the generator
- `fft_level` out clog2(`LEVELS`) (4): current level index to the generator
- `bank_sel` out 1: read bank for current level; write bank is `~bank_sel`
- `level_done` out 1: one-cycle pulse per completed level

## Operation
- States: IDLE, LAUNCH, ARM, RUN, DRAIN, NEXT, DONE, ERROR.
- IDLE: `fft_start`=1 → LAUNCH; clear `fft_level`, `bank_sel`, `fft_error`.
- LAUNCH: `addr_gen_go`=1 this cycle only → ARM.
- ARM: `addr_gen_busy`=1 → RUN; else → ERROR.
- RUN: stay while `addr_gen_busy`=1; on 0 → DRAIN, drain counter cleared to 0.
- DRAIN: counter increments each cycle, saturating at `BFLY_LATENCY`; exit to NEXT when `fft_data_valid`=0 and counter ≥ `BFLY_LATENCY`-1.
- NEXT: `level_done`=1; if `fft_level`=`LEVELS`-1 → DONE; else `fft_level`+1, toggle `bank_sel`, → LAUNCH.
- DONE: `fft_done`=1 → IDLE. `bank_sel` holds final value (result bank) until next start.
- ERROR: `fft_error`=1 (sticky), `fft_busy`=0; `fft_start` → LAUNCH with error cleared; otherwise stay.
- Exactly `LEVELS` `addr_gen_go` pulses per successful frame; none in IDLE, DONE, ERROR.
- `fft_start` in any state other than IDLE/ERROR is ignored (no queuing).
- `fft_level` never wraps; increment only in NEXT below `LEVELS`-1.
- All outputs are registered-state decodes; no combinational path from inputs to outputs.

## Timing
- Reset values: state IDLE; `fft_busy`, `fft_done`, `fft_error`, `addr_gen_go`, `level_done`, `bank_sel` = 0; `fft_level`=0; drain counter 0.
- `reset` mid-frame: return to IDLE next edge, all outputs at reset values; no further `addr_gen_go`.
- `fft_start` sampled at cycle 0 → LAUNCH (`addr_gen_go`=1, `fft_busy`=1) in cycle 1.
- With a conforming generator (busy in the cycle after go for `FFT_SIZE`/2 cycles; valid = busy delayed `BFLY_LATENCY`): level period 2058 cycles at defaults; level L launch at cycle 1+2058·L; NEXT at 2058·(L+1); `fft_done` in cycle 24697; `fft_busy` low from cycle 24698.
- `fft_level`/`bank_sel` change only on the NEXT→LAUNCH edge; stable throughout LAUNCH..NEXT.
- `fft_start` in the DONE cycle is ignored; earliest restart sampled in IDLE.

## Test plan
- Reset, then one frame with behavioural generator model → 12 `addr_gen_go` pulses at cycles 1+2058·L, `fft_level` 0..11, `bank_sel` alternating 0,1,…, `fft_done` once at cycle 24697, final `bank_sel`=1.
- Generator model never asserts busy → ERROR in cycle 3, `fft_error`=1 sticky, `fft_busy`=0, no second `addr_gen_go`; new `fft_start` clears error and relaunches at level 0.
- Hold `fft_data_valid` high 20 extra cycles after busy falls in level 3 → DRAIN extends until valid=0; `level_done` and next launch delayed by exactly 20 cycles.
- `fft_start` pulsed at level 5 and in DONE cycle → ignored; frame completes normally with one `fft_done`.
- `reset` asserted in RUN of level 7 → next cycle all outputs 0, `fft_level`=0; subsequent `fft_start` runs a full clean frame.
- `FFT_SIZE`=16 → 4 levels, `fft_level` width 2, period 1+1+(8)+…; `fft_done` after 4th `level_done`, check with model.
